rx_packet_ctrl: RTL and testbench
=================================

RX_PACKET_CTRL -- requirements
Module: rx_packet_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum accepted payload length in bytes (1..255).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 5000, clocks allowed between consumed bytes inside a packet.
REQ-003 SHALL have ports: clk  in  1  system clock, rising-edge.
REQ-004 SHALL have port: n_rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: rx_data  in  8  received byte from the UART receive block.
REQ-006 SHALL have port: data_ready  in  1  rx_data holds an unread byte.
REQ-007 SHALL have port: overrun_error  in  1  receive-buffer overrun flag (level).
REQ-008 SHALL have port: framing_error  in  1  stop-bit error flag (level).
REQ-009 SHALL have port: data_read  out  1  one-cycle pulse acknowledging the byte to the receive block.
REQ-010 SHALL have port: pkt_data  out  8  payload byte, qualified by pkt_wr.
REQ-011 SHALL have port: pkt_wr  out  1  one-cycle pulse per payload byte.
REQ-012 SHALL have port: pkt_len  out  8  payload length, valid while pkt_done is high.
REQ-013 SHALL have port: pkt_done  out  1  one-cycle pulse on a good packet.
REQ-014 SHALL have port: pkt_error  out  1  one-cycle pulse on an aborted packet.
REQ-015 SHALL have port: err_code  out  2  abort cause, valid while pkt_error is high: 00 timeout, 01 bad length, 10 checksum, 11 line error.

Function
REQ-016 SHALL decode packets framed as SYNC (8'h7E), LEN, LEN payload bytes, then CSUM, where CSUM is the XOR of LEN and all payload bytes.
REQ-017 SHALL implement states IDLE, GET_LEN, GET_PAY, GET_CSUM.
REQ-018 SHALL treat a byte as consumed in cycle N when data_ready=1 and data_read=0; data_read SHALL be 1 in cycle N+1 only, and data_ready SHALL be ignored while data_read=1.
REQ-019 SHALL, in IDLE, discard non-SYNC bytes (still acknowledged) and go to GET_LEN on SYNC.
REQ-020 SHALL, in GET_LEN, abort with code 01 on LEN=0 or LEN>MAX_LEN; otherwise latch LEN, seed the checksum with LEN, and go to GET_PAY.
REQ-021 SHALL, in GET_PAY, output each byte on pkt_data with pkt_wr in cycle N+1, XOR it into the checksum, and go to GET_CSUM after the LEN-th byte.
REQ-022 SHALL, in GET_CSUM, pulse pkt_done with pkt_len=LEN in cycle N+1 on a match, or abort with code 10 on a mismatch; both SHALL return to IDLE.
REQ-023 SHALL abort with code 11 when overrun_error or framing_error is 1 in any non-IDLE state; both flags SHALL be ignored in IDLE.
REQ-024 SHALL run a timeout counter in non-IDLE states, clear it on every consumed byte, and abort with code 00 when it reaches TIMEOUT_CYC-1.
REQ-025 SHALL, on any abort, pulse pkt_error for one cycle and return to IDLE; payload bytes already written are not retracted, and the consumer discards them on pkt_error.
REQ-026 SHALL give a line error priority over a byte consumed in the same cycle; that byte SHALL still be acknowledged and SHALL NOT produce pkt_wr.
REQ-027 SHALL never assert pkt_done and pkt_error in the same cycle.

Reset
REQ-028 SHALL, while n_rst=0, force state IDLE and clear the checksum, the length and payload counters, and the timeout counter.
REQ-029 SHALL drive all outputs to 0 during reset.
REQ-030 SHALL, on reset mid-packet, produce no pkt_done or pkt_error pulse and resume hunting for SYNC.

Configuration
REQ-031 SHALL use macro RX_PKT_CHECKSUM_EN: when defined, the CSUM byte is required as in REQ-016 and REQ-022.
REQ-032 SHALL, when RX_PKT_CHECKSUM_EN is undefined, omit GET_CSUM, pulse pkt_done in the same cycle as the last pkt_wr, and never emit code 10.

Structure
REQ-033 SHALL place the state enum, the err_code enum, and the SYNC_BYTE constant in package rx_pkt_pkg.
REQ-034 SHALL implement the timeout counter as sub-module rx_timeout_cnt (inputs: enable, clear; output: expired), sized by $clog2(TIMEOUT_CYC).

Verification
REQ-035 SHALL cover: bytes 7E 03 11 22 33 03 -> three pkt_wr (11, 22, 33), then pkt_done with pkt_len=3, and six data_read pulses.
REQ-036 SHALL cover: bytes 7E 02 AA BB 00 -> two pkt_wr, then pkt_error with err_code=10 (expected checksum 13).
REQ-037 SHALL cover: bytes 7E 00 and, separately, 7E 11 with MAX_LEN=16 -> pkt_error with err_code=01, no pkt_wr.
REQ-038 SHALL cover: 7E 04 01 then idle for 5000 clocks -> pkt_error with err_code=00 at 4999 clocks after the last consumed byte.
REQ-039 SHALL cover: framing_error=1 during GET_PAY -> pkt_error with err_code=11; a following 7E 01 55 54 -> pkt_done.
REQ-040 SHALL cover: n_rst asserted mid-payload -> all outputs 0, no pulses, and the next valid packet is decoded correctly.

Source files
------------

// File: rtl/rx_pkt_pkg.sv
// Shared types and constants for the UART packet receiver (rx_packet_ctrl).
// The CSUM trailer is only decoded when RX_PKT_CHECKSUM_EN is defined.
package rx_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_GET_LEN  = 2'b01,
        ST_GET_PAY  = 2'b10,
        ST_GET_CSUM = 2'b11
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_TIMEOUT = 2'b00,
        ERR_BAD_LEN = 2'b01,
        ERR_CSUM    = 2'b10,
        ERR_LINE    = 2'b11
    } rx_err_t;

endpackage

// File: rtl/rx_timeout_cnt.sv
// Inter-byte watchdog for rx_packet_ctrl: counts idle clocks while a packet is open.
// TIMEOUT_CYC must be at least 2.
module rx_timeout_cnt #(
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 2);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CNT_FINAL)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Fires on the edge where the count steps onto TIMEOUT_CYC-1, so the
    // registered abort appears TIMEOUT_CYC-1 clocks after the last clear.
    assign expired = enable && !clear && (cnt == CNT_LAST);

endmodule

// File: rtl/rx_packet_ctrl.sv
// Packet framer on top of a UART receive block: SYNC, LEN, payload[, CSUM].
// Define RX_PKT_CHECKSUM_EN to require and verify the trailing XOR checksum byte.
module rx_packet_ctrl
    import rx_pkt_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] rx_data,
    input  logic       data_ready,
    input  logic       overrun_error,
    input  logic       framing_error,
    output logic       data_read,
    output logic [7:0] pkt_data,
    output logic       pkt_wr,
    output logic [7:0] pkt_len,
    output logic       pkt_done,
    output logic       pkt_error,
    output logic [1:0] err_code
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    rx_state_t  state;
    rx_err_t    err_q;
    logic [7:0] len_q;
    logic [7:0] pay_cnt;
    logic [7:0] pay_next;
    logic [7:0] csum;
    logic       consume;
    logic       line_err;
    logic       tmo_enable;
    logic       tmo_clear;
    logic       tmo_expired;

    // A byte is taken only when it is not already being acknowledged.
    assign consume    = data_ready && !data_read;
    assign line_err   = overrun_error || framing_error;
    assign pay_next   = pay_cnt + 8'd1;
    assign tmo_enable = (state != ST_IDLE);
    assign tmo_clear  = consume || (state == ST_IDLE);
    assign err_code   = err_q;

    rx_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .n_rst  (n_rst),
        .enable (tmo_enable),
        .clear  (tmo_clear),
        .expired(tmo_expired)
    );

    // Line errors outrank a byte consumed in the same cycle; timeouts come last.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            err_q     <= ERR_TIMEOUT;
            len_q     <= '0;
            pay_cnt   <= '0;
            csum      <= '0;
            data_read <= 1'b0;
            pkt_data  <= '0;
            pkt_wr    <= 1'b0;
            pkt_len   <= '0;
            pkt_done  <= 1'b0;
            pkt_error <= 1'b0;
        end else begin
            data_read <= consume;
            pkt_wr    <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_error <= 1'b0;
            pkt_len   <= '0;
            err_q     <= ERR_TIMEOUT;

            if ((state != ST_IDLE) && line_err) begin
                pkt_error <= 1'b1;
                err_q     <= ERR_LINE;
                state     <= ST_IDLE;
            end else if (consume) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= ST_GET_LEN;
                        end
                    end
                    ST_GET_LEN: begin
                        if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                            pkt_error <= 1'b1;
                            err_q     <= ERR_BAD_LEN;
                            state     <= ST_IDLE;
                        end else begin
                            len_q   <= rx_data;
                            csum    <= rx_data;
                            pay_cnt <= '0;
                            state   <= ST_GET_PAY;
                        end
                    end
                    ST_GET_PAY: begin
                        pkt_wr   <= 1'b1;
                        pkt_data <= rx_data;
                        csum     <= csum ^ rx_data;
                        pay_cnt  <= pay_next;
                        if (pay_next == len_q) begin
`ifdef RX_PKT_CHECKSUM_EN
                            state <= ST_GET_CSUM;
`else
                            pkt_done <= 1'b1;
                            pkt_len  <= len_q;
                            state    <= ST_IDLE;
`endif
                        end
                    end
`ifdef RX_PKT_CHECKSUM_EN
                    ST_GET_CSUM: begin
                        if (rx_data == csum) begin
                            pkt_done <= 1'b1;
                            pkt_len  <= len_q;
                        end else begin
                            pkt_error <= 1'b1;
                            err_q     <= ERR_CSUM;
                        end
                        state <= ST_IDLE;
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end else if (tmo_expired) begin
                pkt_error <= 1'b1;
                err_q     <= ERR_TIMEOUT;
                state     <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Directed bench for rx_packet_ctrl; expectations follow RX_PKT_CHECKSUM_EN when defined.
module tb_rx_packet_ctrl;

    localparam int MAX_LEN     = 16;
    localparam int TIMEOUT_CYC = 5000;
`ifdef RX_PKT_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       data_ready = 1'b0;
    logic       overrun_error = 1'b0;
    logic       framing_error = 1'b0;
    logic       data_read;
    logic [7:0] pkt_data;
    logic       pkt_wr;
    logic [7:0] pkt_len;
    logic       pkt_done;
    logic       pkt_error;
    logic [1:0] err_code;

    int total = 0;
    int bad   = 0;

    int rd_cnt      = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int both_cnt    = 0;
    int done_wr_cnt = 0;
    logic [7:0] last_len  = 8'h00;
    logic [1:0] last_code = 2'b00;
    logic [7:0] wr_q[$];

    rx_packet_ctrl #(
        .MAX_LEN    (MAX_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .overrun_error(overrun_error),
        .framing_error(framing_error),
        .data_read    (data_read),
        .pkt_data     (pkt_data),
        .pkt_wr       (pkt_wr),
        .pkt_len      (pkt_len),
        .pkt_done     (pkt_done),
        .pkt_error    (pkt_error),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    // Pulse monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (data_read) rd_cnt++;
        if (pkt_wr) wr_q.push_back(pkt_data);
        if (pkt_done) begin
            done_cnt++;
            last_len = pkt_len;
        end
        if (pkt_error) begin
            err_cnt++;
            last_code = err_code;
        end
        if (pkt_done && pkt_error) both_cnt++;
        if (pkt_done && pkt_wr) done_wr_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        @(negedge clk);
        rx_data    = b;
        data_ready = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (data_read) break;
        end
        data_ready = 1'b0;
        if (k == 20) begin
            total++;
            bad++;
            $display("[TB] FAIL ack_wait: byte %02h got no data_read within 20 cycles", b);
        end
    endtask

    task automatic test_reset;
        #12;
        total++;
        if ({data_read, pkt_wr, pkt_done, pkt_error, pkt_data, pkt_len, err_code} !== 27'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %07h want 0",
                     {data_read, pkt_wr, pkt_done, pkt_error, pkt_data, pkt_len, err_code});
        end
        @(negedge clk);
        n_rst = 1'b1;
        idle(2);
    endtask

    task automatic test_good_packet;
        int rd0 = rd_cnt, d0 = done_cnt, e0 = err_cnt, dw0 = done_wr_cnt;
        int w0 = wr_q.size();
        send_byte(8'h7E); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
        idle(4);
        total++;
        if (wr_q.size() - w0 !== 3) begin bad++; $display("[TB] FAIL good_wr_count: got %0d want 3", wr_q.size() - w0); end
        total++;
        if (wr_q.size() >= w0 + 3 && {wr_q[w0], wr_q[w0+1], wr_q[w0+2]} !== 24'h112233) begin
            bad++; $display("[TB] FAIL good_wr_data: got %02h %02h %02h want 11 22 33", wr_q[w0], wr_q[w0+1], wr_q[w0+2]);
        end else if (wr_q.size() < w0 + 3) begin
            bad++; $display("[TB] FAIL good_wr_data: got %0d bytes want 3", wr_q.size() - w0);
        end
        total++;
        if (done_cnt - d0 !== 1 || last_len !== 8'd3) begin
            bad++; $display("[TB] FAIL good_done: got count %0d len %0d want 1 len 3", done_cnt - d0, last_len);
        end
        total++;
        if (rd_cnt - rd0 !== 6) begin bad++; $display("[TB] FAIL good_data_read: got %0d want 6", rd_cnt - rd0); end
        total++;
        if (err_cnt - e0 !== 0) begin bad++; $display("[TB] FAIL good_no_error: got %0d want 0", err_cnt - e0); end
        total++;
        if (done_wr_cnt - dw0 !== (CSUM_EN ? 0 : 1)) begin
            bad++; $display("[TB] FAIL good_done_with_wr: got %0d want %0d", done_wr_cnt - dw0, CSUM_EN ? 0 : 1);
        end
    endtask

    task automatic test_checksum;
        int d0 = done_cnt, e0 = err_cnt;
        int w0 = wr_q.size();
        send_byte(8'h7E); send_byte(8'h02); send_byte(8'hAA);
        send_byte(8'hBB); send_byte(8'h00);
        idle(4);
        total++;
        if (wr_q.size() - w0 !== 2) begin bad++; $display("[TB] FAIL csum_wr_count: got %0d want 2", wr_q.size() - w0); end
        if (CSUM_EN) begin
            total++;
            if (err_cnt - e0 !== 1 || last_code !== 2'b10 || done_cnt - d0 !== 0) begin
                bad++; $display("[TB] FAIL csum_mismatch: got err %0d code %b done %0d want 1 10 0", err_cnt - e0, last_code, done_cnt - d0);
            end
        end else begin
            total++;
            if (done_cnt - d0 !== 1 || last_len !== 8'd2 || err_cnt - e0 !== 0) begin
                bad++; $display("[TB] FAIL nocsum_done: got done %0d len %0d err %0d want 1 2 0", done_cnt - d0, last_len, err_cnt - e0);
            end
        end
    endtask

    task automatic test_bad_length;
        int e0 = err_cnt;
        int w0 = wr_q.size();
        send_byte(8'h7E); send_byte(8'h00);
        idle(3);
        total++;
        if (err_cnt - e0 !== 1 || last_code !== 2'b01) begin
            bad++; $display("[TB] FAIL len_zero: got err %0d code %b want 1 01", err_cnt - e0, last_code);
        end
        send_byte(8'h7E); send_byte(8'h11);
        idle(3);
        total++;
        if (err_cnt - e0 !== 2 || last_code !== 2'b01) begin
            bad++; $display("[TB] FAIL len_over_max: got err %0d code %b want 2 01", err_cnt - e0, last_code);
        end
        total++;
        if (wr_q.size() - w0 !== 0) begin bad++; $display("[TB] FAIL len_no_wr: got %0d want 0", wr_q.size() - w0); end
    endtask

    task automatic test_max_len;
        int d0 = done_cnt, e0 = err_cnt;
        int w0 = wr_q.size();
        send_byte(8'h7E);
        send_byte(8'h10);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        send_byte(8'h10);
        idle(4);
        total++;
        if (done_cnt - d0 !== 1 || last_len !== 8'd16 || err_cnt - e0 !== 0) begin
            bad++; $display("[TB] FAIL max_len_done: got done %0d len %0d err %0d want 1 16 0", done_cnt - d0, last_len, err_cnt - e0);
        end
        total++;
        if (wr_q.size() - w0 !== 16 || (wr_q.size() >= w0 + 16 && wr_q[w0+15] !== 8'h0F)) begin
            bad++; $display("[TB] FAIL max_len_wr: got %0d bytes want 16 ending 0f", wr_q.size() - w0);
        end
    endtask

    task automatic test_timeout;
        int e0 = err_cnt;
        int w0 = wr_q.size();
        int k;
        logic [1:0] code_seen;
        send_byte(8'h7E); send_byte(8'h04); send_byte(8'h01);
        code_seen = 2'bxx;
        for (k = 1; k <= TIMEOUT_CYC + 100; k++) begin
            @(posedge clk);
            #1;
            if (pkt_error) begin
                code_seen = err_code;
                break;
            end
        end
        total++;
        if (k !== TIMEOUT_CYC - 1) begin
            bad++; $display("[TB] FAIL timeout_latency: got %0d clocks want %0d", k, TIMEOUT_CYC - 1);
        end
        total++;
        if (code_seen !== 2'b00) begin bad++; $display("[TB] FAIL timeout_code: got %b want 00", code_seen); end
        idle(3);
        total++;
        if (err_cnt - e0 !== 1 || wr_q.size() - w0 !== 1) begin
            bad++; $display("[TB] FAIL timeout_counts: got err %0d wr %0d want 1 1", err_cnt - e0, wr_q.size() - w0);
        end
    endtask

    task automatic test_line_error;
        int d0, e0 = err_cnt;
        int w0 = wr_q.size();
        send_byte(8'h7E); send_byte(8'h03); send_byte(8'hA1);
        @(negedge clk);
        framing_error = 1'b1;
        @(negedge clk);
        framing_error = 1'b0;
        idle(3);
        total++;
        if (err_cnt - e0 !== 1 || last_code !== 2'b11 || wr_q.size() - w0 !== 1) begin
            bad++; $display("[TB] FAIL line_abort: got err %0d code %b wr %0d want 1 11 1", err_cnt - e0, last_code, wr_q.size() - w0);
        end
        d0 = done_cnt;
        w0 = wr_q.size();
        send_byte(8'h7E); send_byte(8'h01); send_byte(8'h55); send_byte(8'h54);
        idle(4);
        total++;
        if (done_cnt - d0 !== 1 || last_len !== 8'd1 || wr_q.size() - w0 !== 1 ||
            (wr_q.size() > w0 && wr_q[w0] !== 8'h55)) begin
            bad++; $display("[TB] FAIL line_recover: got done %0d len %0d wr %0d want 1 1 1 (55)", done_cnt - d0, last_len, wr_q.size() - w0);
        end
    endtask

    task automatic test_line_priority;
        int rd0 = rd_cnt, e0 = err_cnt;
        int w0 = wr_q.size();
        int k;
        send_byte(8'h7E); send_byte(8'h02);
        @(negedge clk);
        rx_data       = 8'hAA;
        data_ready    = 1'b1;
        framing_error = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (data_read) break;
        end
        data_ready    = 1'b0;
        framing_error = 1'b0;
        idle(3);
        total++;
        if (rd_cnt - rd0 !== 3) begin bad++; $display("[TB] FAIL prio_ack: got %0d want 3", rd_cnt - rd0); end
        total++;
        if (wr_q.size() - w0 !== 0 || err_cnt - e0 !== 1 || last_code !== 2'b11) begin
            bad++; $display("[TB] FAIL prio_abort: got wr %0d err %0d code %b want 0 1 11", wr_q.size() - w0, err_cnt - e0, last_code);
        end
    endtask

    task automatic test_idle_flags;
        int rd0 = rd_cnt, e0 = err_cnt;
        @(negedge clk);
        overrun_error = 1'b1;
        framing_error = 1'b1;
        idle(5);
        send_byte(8'h5A);
        idle(3);
        overrun_error = 1'b0;
        framing_error = 1'b0;
        total++;
        if (err_cnt - e0 !== 0 || rd_cnt - rd0 !== 1) begin
            bad++; $display("[TB] FAIL idle_flags: got err %0d reads %0d want 0 1", err_cnt - e0, rd_cnt - rd0);
        end
    endtask

    task automatic test_reset_mid_packet;
        int d0, e0;
        int w0;
        send_byte(8'h7E); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        @(negedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        n_rst = 1'b0;
        #1;
        total++;
        if ({data_read, pkt_wr, pkt_done, pkt_error, pkt_data, pkt_len, err_code} !== 27'd0) begin
            bad++; $display("[TB] FAIL midreset_outputs: got %07h want 0",
                            {data_read, pkt_wr, pkt_done, pkt_error, pkt_data, pkt_len, err_code});
        end
        idle(3);
        @(negedge clk);
        n_rst = 1'b1;
        idle(4);
        total++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            bad++; $display("[TB] FAIL midreset_no_pulse: got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0);
        end
        w0 = wr_q.size();
        send_byte(8'h7E); send_byte(8'h02); send_byte(8'hC3); send_byte(8'h3C); send_byte(8'hFD);
        idle(4);
        total++;
        if (done_cnt - d0 !== 1 || last_len !== 8'd2 || err_cnt - e0 !== 0 || wr_q.size() - w0 !== 2 ||
            (wr_q.size() >= w0 + 2 && {wr_q[w0], wr_q[w0+1]} !== 16'hC33C)) begin
            bad++; $display("[TB] FAIL midreset_next_pkt: got done %0d len %0d err %0d wr %0d want 1 2 0 2",
                            done_cnt - d0, last_len, err_cnt - e0, wr_q.size() - w0);
        end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_checksum();
        test_bad_length();
        test_max_len();
        test_timeout();
        test_line_error();
        test_line_priority();
        test_idle_flags();
        test_reset_mid_packet();
        total++;
        if (both_cnt !== 0) begin bad++; $display("[TB] FAIL done_and_error: got %0d want 0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
